code_gen_ctrl: RTL and testbench

- Controller that owns the 32-bit RNG and sequences it to produce a MasterMind secret code of PEGS digits, each in 0..COLORS-1.
- Loads the RNG seed on reset or on request, then keeps the RNG free-running so player timing adds entropy.
- On start, draws digits with rejection sampling, plus an optional no-repeat rule and a bounded-latency fallback.
- Presents the packed code to the game FSM with a busy/done handshake.

---
 rtl/code_gen_ctrl.sv | 179 +++++++++++++++++
 tb/tb_code_gen_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/code_gen_ctrl.sv
// MasterMind secret-code generator: seeds and steps the RNG, draws PEGS digits by
// rejection sampling with optional no-repeat and a bounded fallback, then hands off the code.
module code_gen_ctrl #(
  parameter int          PEGS      = 4,
  parameter int          COLORS    = 6,
  parameter int          COLOR_W   = 3,
  parameter int          MAX_TRIES = 16,
  parameter logic [31:0] INIT_SEED = 32'h00000091
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      seed_load,
  input  logic [31:0]               seed_in,
  input  logic                      no_repeat,
  output logic                      rng_en,
  output logic [31:0]               rng_seed,
  input  logic [31:0]               rng_value,
  output logic [PEGS*COLOR_W-1:0]   code,
  output logic                      busy,
  output logic                      done
);

  localparam int NSYM       = 1 << COLOR_W;
  localparam int PEG_W      = (PEGS > 1) ? $clog2(PEGS) : 1;
  localparam int TRY_W      = $clog2(MAX_TRIES + 1);
  localparam bit NR_ALLOWED = (COLORS >= PEGS);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_SEED = 3'd1,
    ST_IDLE = 3'd2,
    ST_DRAW = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                    state_r;
  logic                      pending_r;
  logic                      nr_r;
  logic [PEG_W-1:0]          peg_r;
  logic [TRY_W-1:0]          tries_r;
  logic [NSYM-1:0]           used_r;
  logic [PEGS*COLOR_W-1:0]   shadow_r;

  logic [COLOR_W-1:0]        cand_s;
  logic [COLOR_W-1:0]        digit_s;
  logic                      in_range_s;
  logic                      dup_s;
  logic                      fallback_s;
  logic                      accept_s;
  logic                      last_s;
  logic [31:0]               seed_sel_s;
  logic                      unused_s;

  function automatic logic [COLOR_W-1:0] smallest_unused(input logic [NSYM-1:0] used);
    logic [COLOR_W-1:0] r;
    r = '0;
    for (int i = COLORS - 1; i >= 0; i--) begin
      if (!used[i]) begin
        r = COLOR_W'(i);
      end
    end
    return r;
  endfunction

  assign unused_s = ^rng_value[31:COLOR_W];

  // Candidate evaluation for the current DRAW cycle and seed selection for a reload.
  always_comb begin
    cand_s     = rng_value[COLOR_W-1:0];
    in_range_s = (32'(cand_s) < 32'(COLORS));
    dup_s      = nr_r & used_r[cand_s];
    fallback_s = (tries_r == TRY_W'(MAX_TRIES));
    last_s     = (peg_r == PEG_W'(PEGS - 1));
    if (fallback_s) begin
      digit_s  = nr_r ? smallest_unused(used_r) : {COLOR_W{1'b0}};
      accept_s = 1'b1;
    end else begin
      digit_s  = cand_s;
      accept_s = in_range_s & ~dup_s;
    end
    if (seed_in != 32'h0) begin
      seed_sel_s = seed_in;
    end else begin
      seed_sel_s = INIT_SEED;
    end
  end

  // Control FSM; every output is registered and reflects the state just entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_INIT;
      pending_r <= 1'b0;
      nr_r      <= 1'b0;
      peg_r     <= '0;
      tries_r   <= '0;
      used_r    <= '0;
      shadow_r  <= '0;
      rng_en    <= 1'b0;
      rng_seed  <= 32'h0;
      code      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_INIT: begin
          state_r   <= ST_SEED;
          rng_seed  <= INIT_SEED;
          rng_en    <= 1'b0;
          pending_r <= 1'b0;
        end
        ST_SEED: begin
          rng_seed <= 32'h0;
          rng_en   <= 1'b1;
          if (pending_r) begin
            state_r   <= ST_DRAW;
            busy      <= 1'b1;
            pending_r <= 1'b0;
            peg_r     <= '0;
            tries_r   <= '0;
            used_r    <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (seed_load) begin
            state_r   <= ST_SEED;
            rng_seed  <= seed_sel_s;
            rng_en    <= 1'b0;
            pending_r <= start;
            if (start) begin
              nr_r <= no_repeat & NR_ALLOWED;
            end else begin
              nr_r <= nr_r;
            end
          end else if (start) begin
            state_r <= ST_DRAW;
            busy    <= 1'b1;
            nr_r    <= no_repeat & NR_ALLOWED;
            peg_r   <= '0;
            tries_r <= '0;
            used_r  <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAW: begin
          if (accept_s) begin
            shadow_r[peg_r*COLOR_W +: COLOR_W] <= digit_s;
            used_r[digit_s] <= 1'b1;
            tries_r         <= '0;
            if (last_s) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
            end else begin
              peg_r <= peg_r + PEG_W'(1);
            end
          end else begin
            tries_r <= tries_r + TRY_W'(1);
          end
        end
        ST_DONE: begin
          code    <= shadow_r;
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_INIT;
          rng_en   <= 1'b0;
          rng_seed <= 32'h0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_gen_ctrl.sv
// Directed bench for code_gen_ctrl: a stub RNG feeds hand-picked low bits and
// outputs are checked one time unit after each rising edge.
module tb_code_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        seed_load;
  logic [31:0] seed_in;
  logic        no_repeat;
  logic        rng_en;
  logic [31:0] rng_seed;
  logic [31:0] rng_value;
  logic [11:0] code;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] stim_q[$];

  code_gen_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .no_repeat (no_repeat),
    .rng_en    (rng_en),
    .rng_seed  (rng_seed),
    .rng_value (rng_value),
    .code      (code),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed queued RNG values until busy drops, then check the DONE handoff.
  task automatic draw_until_done(input string tag, input int exp_cycles, input logic [11:0] exp_code);
    int cycles;
    cycles = 0;
    while (busy && cycles < 300) begin
      if (stim_q.size() > 0) rng_value = stim_q.pop_front();
      tick();
      start = 1'b0;
      cycles++;
    end
    check({tag, " draw cycles"}, 32'(cycles), 32'(exp_cycles));
    check({tag, " done before"}, 32'(done), 32'h0);
    tick();
    check({tag, " done"}, 32'(done), 32'h1);
    check({tag, " code"}, 32'(code), 32'(exp_code));
    tick();
    check({tag, " done end"}, 32'(done), 32'h0);
  endtask

  task automatic start_code(input string tag, input logic nr);
    no_repeat = nr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    no_repeat = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'h1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    seed_load = 1'b0;
    seed_in   = 32'h0;
    no_repeat = 1'b0;
    rng_value = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst rng_seed", rng_seed, 32'h0);
    check("rst rng_en", 32'(rng_en), 32'h0);
    check("rst code", 32'(code), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    check("seed cyc rng_seed", rng_seed, 32'h91);
    check("seed cyc rng_en", 32'(rng_en), 32'h0);
    tick();
    check("idle rng_seed", rng_seed, 32'h0);
    check("idle rng_en", 32'(rng_en), 32'h1);
    tick();
    check("idle rng_en hold", 32'(rng_en), 32'h1);
    check("idle busy", 32'(busy), 32'h0);

    stim_q = '{32'h1, 32'h2, 32'h3, 32'h4};
    start_code("basic", 1'b0);
    draw_until_done("basic", 4, 12'h8D1);

    stim_q = '{32'h7, 32'h6, 32'h1, 32'h1, 32'h2, 32'h5, 32'h0};
    start_code("norep", 1'b1);
    draw_until_done("norep", 7, 12'h151);

    rng_value = 32'h7;
    start_code("stuck nr", 1'b1);
    draw_until_done("stuck nr", 68, 12'h688);
    start_code("stuck rep", 1'b0);
    draw_until_done("stuck rep", 68, 12'h000);

    seed_load = 1'b1;
    seed_in   = 32'hDEADBEEF;
    start     = 1'b1;
    tick();
    seed_load = 1'b0;
    start     = 1'b0;
    check("reseed rng_seed", rng_seed, 32'hDEADBEEF);
    check("reseed rng_en", 32'(rng_en), 32'h0);
    check("reseed busy", 32'(busy), 32'h0);
    tick();
    check("reseed->draw rng_seed", rng_seed, 32'h0);
    check("reseed->draw rng_en", 32'(rng_en), 32'h1);
    check("reseed->draw busy", 32'(busy), 32'h1);
    stim_q = '{32'h5, 32'h4, 32'h3, 32'h2};
    start  = 1'b1;
    draw_until_done("pending", 4, 12'h4E5);
    for (int i = 0; i < 8; i++) begin
      check("no second done", 32'({busy, done}), 32'h0);
      tick();
    end

    seed_load = 1'b1;
    seed_in   = 32'h0;
    tick();
    seed_load = 1'b0;
    check("zero seed rng_seed", rng_seed, 32'h91);
    check("zero seed rng_en", 32'(rng_en), 32'h0);
    tick();
    check("zero seed idle rng_seed", rng_seed, 32'h0);
    check("zero seed idle busy", 32'(busy), 32'h0);

    stim_q = '{32'h1, 32'h2};
    start_code("abort", 1'b1);
    rng_value = stim_q.pop_front();
    tick();
    rng_value = stim_q.pop_front();
    tick();
    rng_value = 32'h7;
    tick();
    check("abort busy pre", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'h0);
    check("abort done", 32'(done), 32'h0);
    check("abort code", 32'(code), 32'h0);
    check("abort rng_en", 32'(rng_en), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("abort seed rng_seed", rng_seed, 32'h91);
    tick();
    check("abort idle rng_seed", rng_seed, 32'h0);
    stim_q = '{32'h3, 32'h1, 32'h0, 32'h2};
    start_code("fresh", 1'b1);
    draw_until_done("fresh", 4, 12'h40B);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
